// File: rtl/seg7_btn_periph_if.sv
// seg7_btn_periph_if: data-memory port carrying load/store strobes, address and data
interface seg7_btn_periph_if #(
  parameter int XLEN = 32
);
  logic            wr_en_i;
  logic            rd_en_i;
  logic [XLEN-1:0] addr_i;
  logic [XLEN-1:0] wr_data_i;
  logic [XLEN-1:0] rd_data_o;
  modport master (output wr_en_i, rd_en_i, addr_i, wr_data_i, input rd_data_o);
  modport slave  (input wr_en_i, rd_en_i, addr_i, wr_data_i, output rd_data_o);
endinterface

// File: rtl/seg7_btn_periph.sv
// seg7_btn_periph: memory-mapped multiplexed 7-segment display with debounced button interrupt
module seg7_btn_periph #(
  parameter int              XLEN            = 32,
  parameter logic [XLEN-1:0] BASE_ADDR       = 'h400,
  parameter int              NUM_DIGITS      = 4,
  parameter int              REFRESH_DIV     = 1000,
  parameter int              DEBOUNCE_CYCLES = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  seg7_btn_periph_if.slave      bus,
  input  logic                  btn_i,
  output logic [6:0]            seg_o,
  output logic [NUM_DIGITS-1:0] an_o,
  output logic                  irq_o
);
  localparam int DW = NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1;
  localparam int RW = $clog2(REFRESH_DIV);
  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam int AW = XLEN - 2;
  logic [AW-1:0]   widx;
  logic            ctrl_hit;
  logic            dig_hit;
  logic [6:0]      digit_q [NUM_DIGITS];
  logic            irq_en_q;
  logic            pend_q;
  logic            sync1_q;
  logic            sync_q;
  logic            stable_q;
  logic            stable_d_q;
  logic [CW-1:0]   dcnt_q;
  logic [RW-1:0]   rcnt_q;
  logic [DW-1:0]   idx_q;
  logic [6:0]      cur_seg;
  logic [XLEN-1:0] rd_val;
  logic            wr_ctrl;
  logic            rise;
  logic            wrap;
  logic            unused;
  // word index relative to the window; the byte-offset bits drop out of the shift
  assign widx     = AW'((bus.addr_i - BASE_ADDR) >> 2);
  assign ctrl_hit = widx == AW'(4);
  assign dig_hit  = widx < AW'(NUM_DIGITS) && !ctrl_hit;
  assign wr_ctrl  = bus.wr_en_i && ctrl_hit;
  assign rise     = stable_q && !stable_d_q;
  assign wrap     = rcnt_q == RW'(REFRESH_DIV - 1);
  assign irq_o    = pend_q && irq_en_q;
  assign unused   = ^bus.wr_data_i[XLEN-1:7];
  // register file: digit segment patterns, irq enable and sticky pending (set beats clear)
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int k = 0; k < NUM_DIGITS; k++) digit_q[k] <= '0;
      irq_en_q <= 1'b0;
      pend_q   <= 1'b0;
    end else begin
      for (int k = 0; k < NUM_DIGITS; k++)
        if (bus.wr_en_i && dig_hit && widx == AW'(k)) digit_q[k] <= bus.wr_data_i[6:0];
      if (wr_ctrl) irq_en_q <= bus.wr_data_i[0];
      pend_q <= rise ? 1'b1 : (wr_ctrl && bus.wr_data_i[1]) ? 1'b0 : pend_q;
    end
  end
  // load data mux; unmapped offsets read as zero
  always_comb begin
    rd_val = '0;
    if (ctrl_hit) rd_val[2:0] = {stable_q, pend_q, irq_en_q};
    for (int k = 0; k < NUM_DIGITS; k++)
      if (dig_hit && widx == AW'(k)) rd_val[6:0] = digit_q[k];
  end
  // registered load data, held between loads
  always_ff @(posedge clk_i) begin
    if (rst_i) bus.rd_data_o <= '0;
    else if (bus.rd_en_i) bus.rd_data_o <= rd_val;
  end
  // synchronize the raw button and accept a new level only after it persists
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync1_q    <= 1'b0;
      sync_q     <= 1'b0;
      stable_q   <= 1'b0;
      stable_d_q <= 1'b0;
      dcnt_q     <= '0;
    end else begin
      sync1_q    <= btn_i;
      sync_q     <= sync1_q;
      stable_d_q <= stable_q;
      if (sync_q == stable_q) dcnt_q <= '0;
      else if (dcnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
        stable_q <= sync_q;
        dcnt_q   <= '0;
      end else dcnt_q <= dcnt_q + 1'b1;
    end
  end
  // segment pattern of the currently scanned digit
  always_comb begin
    cur_seg = '0;
    for (int k = 0; k < NUM_DIGITS; k++)
      if (idx_q == DW'(k)) cur_seg = digit_q[k];
  end
  // refresh scan: each digit stays lit REFRESH_DIV cycles, outputs registered from the index
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rcnt_q <= '0;
      idx_q  <= '0;
      an_o   <= NUM_DIGITS'(1);
      seg_o  <= '0;
    end else begin
      rcnt_q <= wrap ? '0 : rcnt_q + 1'b1;
      if (wrap) idx_q <= idx_q == DW'(NUM_DIGITS - 1) ? '0 : idx_q + 1'b1;
      an_o  <= NUM_DIGITS'(1) << idx_q;
      seg_o <= cur_seg;
    end
  end
endmodule

// File: tb/tb_seg7_btn_periph.sv
// tb_seg7_btn_periph: table-driven register checks with a read scoreboard plus scan and button sequences
module tb_seg7_btn_periph;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       btn = 1'b0;
  logic [6:0] seg;
  logic [3:0] an;
  logic       irq;
  int         checks = 0;
  int         errors = 0;
  logic [31:0] sb [$];
  typedef struct {
    logic        wr;
    logic        rd;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp;
  } vec_t;
  localparam int NV = 20;
  vec_t vecs [NV];
  seg7_btn_periph_if #(.XLEN(32)) bus ();
  seg7_btn_periph #(
    .XLEN(32), .BASE_ADDR(32'h400), .NUM_DIGITS(4), .REFRESH_DIV(4), .DEBOUNCE_CYCLES(4)
  ) dut (
    .clk_i(clk), .rst_i(rst), .bus(bus), .btn_i(btn), .seg_o(seg), .an_o(an), .irq_o(irq)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic tick_n(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask
  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    bus.wr_en_i = 1'b1;
    bus.addr_i = a;
    bus.wr_data_i = d;
    tick();
    bus.wr_en_i = 1'b0;
  endtask
  task automatic rd(input logic [31:0] a, input logic [31:0] e);
    bus.rd_en_i = 1'b1;
    bus.addr_i = a;
    sb.push_back(e);
    tick();
    bus.rd_en_i = 1'b0;
  endtask
  always @(posedge clk) begin
    if (bus.rd_en_i === 1'b1 && !rst) begin
      #1;
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_underflow: got read data %h with no expected entry", bus.rd_data_o);
      end else chk("rd_data", bus.rd_data_o, sb.pop_front());
    end
  end
  initial begin
    int  n;
    logic seen;
    vecs[0]  = '{1'b1, 1'b0, 32'h408, 32'hFFFF_FFFF, 32'h0};
    vecs[1]  = '{1'b0, 1'b1, 32'h408, 32'h0,         32'h7F};
    vecs[2]  = '{1'b0, 1'b1, 32'h420, 32'h0,         32'h0};
    vecs[3]  = '{1'b1, 1'b0, 32'h420, 32'h1234_5678, 32'h0};
    vecs[4]  = '{1'b0, 1'b1, 32'h400, 32'h0,         32'h3F};
    vecs[5]  = '{1'b0, 1'b1, 32'h404, 32'h0,         32'h06};
    vecs[6]  = '{1'b0, 1'b1, 32'h408, 32'h0,         32'h7F};
    vecs[7]  = '{1'b0, 1'b1, 32'h40C, 32'h0,         32'h0};
    vecs[8]  = '{1'b0, 1'b1, 32'h420, 32'h0,         32'h0};
    vecs[9]  = '{1'b1, 1'b1, 32'h40C, 32'h55,        32'h0};
    vecs[10] = '{1'b0, 1'b1, 32'h40C, 32'h0,         32'h55};
    vecs[11] = '{1'b0, 1'b1, 32'h402, 32'h0,         32'h3F};
    vecs[12] = '{1'b0, 1'b1, 32'h410, 32'h0,         32'h0};
    vecs[13] = '{1'b0, 1'b1, 32'h3FC, 32'h0,         32'h0};
    vecs[14] = '{1'b1, 1'b0, 32'h410, 32'hFFFF_FFF9, 32'h0};
    vecs[15] = '{1'b0, 1'b1, 32'h410, 32'h0,         32'h1};
    vecs[16] = '{1'b1, 1'b0, 32'h410, 32'h0,         32'h0};
    vecs[17] = '{1'b0, 1'b1, 32'h410, 32'h0,         32'h0};
    vecs[18] = '{1'b1, 1'b0, 32'h414, 32'hFF,        32'h0};
    vecs[19] = '{1'b0, 1'b1, 32'h414, 32'h0,         32'h0};
    bus.wr_en_i = 1'b0;
    bus.rd_en_i = 1'b0;
    bus.addr_i = '0;
    bus.wr_data_i = '0;
    tick_n(3);
    rst = 1'b0;
    chk("reset_seg", 32'(seg), 32'h0);
    chk("reset_an", 32'(an), 32'h1);
    chk("reset_irq", 32'(irq), 32'h0);
    rd(32'h410, 32'h0);
    wr(32'h400, 32'h3F);
    wr(32'h404, 32'h06);
    n = 0;
    while (an !== 4'b1000 && n < 40) begin tick(); n++; end
    while (an !== 4'b0001 && n < 40) begin tick(); n++; end
    chk("scan_sync", 32'(n < 40), 32'h1);
    for (int i = 0; i < 4; i++) begin
      chk("dwell0_an", 32'(an), 32'h1);
      chk("dwell0_seg", 32'(seg), 32'h3F);
      tick();
    end
    chk("dig1_an", 32'(an), 32'h2);
    chk("dig1_seg", 32'(seg), 32'h06);
    tick_n(12);
    chk("frame_an", 32'(an), 32'h1);
    chk("frame_seg", 32'(seg), 32'h3F);
    for (int i = 0; i < NV; i++) begin
      bus.wr_en_i = vecs[i].wr;
      bus.rd_en_i = vecs[i].rd;
      bus.addr_i = vecs[i].addr;
      bus.wr_data_i = vecs[i].wdata;
      if (vecs[i].rd) sb.push_back(vecs[i].exp);
      tick();
    end
    bus.wr_en_i = 1'b0;
    bus.rd_en_i = 1'b0;
    wr(32'h410, 32'h1);
    btn = 1'b1;
    tick_n(3);
    btn = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin tick(); seen |= irq; end
    chk("glitch_irq", 32'(seen), 32'h0);
    rd(32'h410, 32'h1);
    btn = 1'b1;
    n = 0;
    do begin tick(); n++; end while (!irq && n < 20);
    chk("btn_latency", n, 7);
    rd(32'h410, 32'h7);
    wr(32'h410, 32'h3);
    chk("w1c_irq", 32'(irq), 32'h0);
    rd(32'h410, 32'h5);
    btn = 1'b0;
    tick_n(10);
    rd(32'h410, 32'h1);
    btn = 1'b1;
    tick_n(6);
    chk("pre_set_irq", 32'(irq), 32'h0);
    wr(32'h410, 32'h3);
    chk("set_wins_irq", 32'(irq), 32'h1);
    rd(32'h410, 32'h7);
    wr(32'h410, 32'h2);
    chk("mask_clear_irq", 32'(irq), 32'h0);
    btn = 1'b0;
    tick_n(10);
    btn = 1'b1;
    tick_n(10);
    chk("masked_irq", 32'(irq), 32'h0);
    rd(32'h410, 32'h6);
    wr(32'h410, 32'h1);
    chk("unmask_irq", 32'(irq), 32'h1);
    tick_n(2);
    chk("sb_drain", sb.size(), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
